// File: rtl/ysyx_23060229_xbar.sv
// ysyx_23060229_xbar
// AXI4 1-to-2 crossbar between the core's io_master port (s_*) and two
// downstream slaves: m0 (main memory window) and m1 (MMIO window).
// Addresses that hit neither window are answered internally with DECERR.
// The read and write paths are independent FSMs. Each path carries one
// transaction at a time.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both 1. valid never waits for ready, and the
// payload holds steady while valid=1 and ready=0.
//
// Ports:
//   clock, reset               single clock, asynchronous active-low reset
//   s_ar*/s_r*/s_aw*/s_w*/s_b* upstream slave port (from the core)
//   m0_*/m1_*                  downstream master ports (memory / MMIO)
//   o_dbg_rstate/o_dbg_wstate  current read / write FSM state, for checkers
module ysyx_23060229_xbar #(
  parameter logic [31:0] M0_BASE = 32'h8000_0000,
  parameter logic [31:0] M0_MASK = 32'hF800_0000,
  parameter logic [31:0] M1_BASE = 32'h1000_0000,
  parameter logic [31:0] M1_MASK = 32'hF000_0000
) (
  input  logic        clock,
  input  logic        reset,
  // upstream AR / R
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  // upstream AW / W / B
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [3:0]  s_awid,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  output logic [3:0]  s_bid,
  // downstream m0
  output logic        m0_arvalid,
  input  logic        m0_arready,
  output logic [31:0] m0_araddr,
  output logic [3:0]  m0_arid,
  output logic [7:0]  m0_arlen,
  output logic [2:0]  m0_arsize,
  output logic [1:0]  m0_arburst,
  input  logic        m0_rvalid,
  output logic        m0_rready,
  input  logic [31:0] m0_rdata,
  input  logic [1:0]  m0_rresp,
  input  logic        m0_rlast,
  input  logic [3:0]  m0_rid,
  output logic        m0_awvalid,
  input  logic        m0_awready,
  output logic [31:0] m0_awaddr,
  output logic [3:0]  m0_awid,
  output logic [7:0]  m0_awlen,
  output logic [2:0]  m0_awsize,
  output logic [1:0]  m0_awburst,
  output logic        m0_wvalid,
  input  logic        m0_wready,
  output logic [31:0] m0_wdata,
  output logic [3:0]  m0_wstrb,
  output logic        m0_wlast,
  input  logic        m0_bvalid,
  output logic        m0_bready,
  input  logic [1:0]  m0_bresp,
  input  logic [3:0]  m0_bid,
  // downstream m1
  output logic        m1_arvalid,
  input  logic        m1_arready,
  output logic [31:0] m1_araddr,
  output logic [3:0]  m1_arid,
  output logic [7:0]  m1_arlen,
  output logic [2:0]  m1_arsize,
  output logic [1:0]  m1_arburst,
  input  logic        m1_rvalid,
  output logic        m1_rready,
  input  logic [31:0] m1_rdata,
  input  logic [1:0]  m1_rresp,
  input  logic        m1_rlast,
  input  logic [3:0]  m1_rid,
  output logic        m1_awvalid,
  input  logic        m1_awready,
  output logic [31:0] m1_awaddr,
  output logic [3:0]  m1_awid,
  output logic [7:0]  m1_awlen,
  output logic [2:0]  m1_awsize,
  output logic [1:0]  m1_awburst,
  output logic        m1_wvalid,
  input  logic        m1_wready,
  output logic [31:0] m1_wdata,
  output logic [3:0]  m1_wstrb,
  output logic        m1_wlast,
  input  logic        m1_bvalid,
  output logic        m1_bready,
  input  logic [1:0]  m1_bresp,
  input  logic [3:0]  m1_bid,
  // debug
  output logic [1:0]  o_dbg_rstate,
  output logic [1:0]  o_dbg_wstate
);

  typedef enum logic [1:0] {T_M0 = 2'd0, T_M1 = 2'd1, T_ERR = 2'd2} tgt_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

  // m0 wins when both windows match
  function automatic tgt_e decode(input logic [31:0] a);
    if ((a & M0_MASK) == M0_BASE)      return T_M0;
    else if ((a & M1_MASK) == M1_BASE) return T_M1;
    else                               return T_ERR;
  endfunction

  // ---------------- read path ----------------
  rstate_e     r_rstate;
  tgt_e        r_rtgt;
  logic        r_arready;
  logic [31:0] r_raddr;
  logic [3:0]  r_rid;
  logic [7:0]  r_rlen;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [7:0]  r_rbeat;
  tgt_e        w_ar_tgt;
  logic        w_m_arready;

  assign w_ar_tgt    = decode(s_araddr);
  assign w_m_arready = (r_rtgt == T_M0) ? m0_arready : m1_arready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_rtgt    <= T_M0;
      r_arready <= 1'b0;
      r_raddr   <= '0;
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rbeat   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s_arvalid && r_arready) begin
            r_raddr   <= s_araddr;
            r_rid     <= s_arid;
            r_rlen    <= s_arlen;
            r_rsize   <= s_arsize;
            r_rburst  <= s_arburst;
            r_rtgt    <= w_ar_tgt;
            r_rbeat   <= '0;
            r_arready <= 1'b0;
            r_rstate  <= (w_ar_tgt == T_ERR) ? R_ERR : R_ADDR;
          end else begin
            // first edge after reset release raises arready
            r_arready <= 1'b1;
          end
        end
        R_ADDR: begin
          if (w_m_arready) r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (s_rvalid && s_rready && s_rlast) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
          end
        end
        R_ERR: begin
          if (s_rready) begin
            if (r_rbeat == r_rlen) begin
              r_rstate  <= R_IDLE;
              r_arready <= 1'b1;
              r_rbeat   <= '0;
            end else begin
              r_rbeat <= r_rbeat + 8'd1;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_arready  = r_arready;
  assign m0_arvalid = (r_rstate == R_ADDR) && (r_rtgt == T_M0);
  assign m1_arvalid = (r_rstate == R_ADDR) && (r_rtgt == T_M1);
  assign m0_araddr  = r_raddr;
  assign m0_arid    = r_rid;
  assign m0_arlen   = r_rlen;
  assign m0_arsize  = r_rsize;
  assign m0_arburst = r_rburst;
  assign m1_araddr  = r_raddr;
  assign m1_arid    = r_rid;
  assign m1_arlen   = r_rlen;
  assign m1_arsize  = r_rsize;
  assign m1_arburst = r_rburst;

  always_comb begin
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = 1'b0;
    s_rid     = '0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
    if (r_rstate == R_DATA) begin
      if (r_rtgt == T_M0) begin
        s_rvalid  = m0_rvalid;
        s_rdata   = m0_rdata;
        s_rresp   = m0_rresp;
        s_rlast   = m0_rlast;
        s_rid     = m0_rid;
        m0_rready = s_rready;
      end else if (r_rtgt == T_M1) begin
        s_rvalid  = m1_rvalid;
        s_rdata   = m1_rdata;
        s_rresp   = m1_rresp;
        s_rlast   = m1_rlast;
        s_rid     = m1_rid;
        m1_rready = s_rready;
      end
    end else if (r_rstate == R_ERR) begin
      s_rvalid = 1'b1;
      s_rresp  = 2'b11;
      s_rid    = r_rid;
      s_rlast  = (r_rbeat == r_rlen);
    end
  end

  // ---------------- write path ----------------
  wstate_e     r_wstate;
  tgt_e        r_wtgt;
  logic        r_awready;
  logic [31:0] r_waddr;
  logic [3:0]  r_wid;
  logic [7:0]  r_wlen;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  tgt_e        w_aw_tgt;
  logic        w_m_awready;

  assign w_aw_tgt    = decode(s_awaddr);
  assign w_m_awready = (r_wtgt == T_M0) ? m0_awready : m1_awready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_wtgt    <= T_M0;
      r_awready <= 1'b0;
      r_waddr   <= '0;
      r_wid     <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s_awvalid && r_awready) begin
            r_waddr   <= s_awaddr;
            r_wid     <= s_awid;
            r_wlen    <= s_awlen;
            r_wsize   <= s_awsize;
            r_wburst  <= s_awburst;
            r_wtgt    <= w_aw_tgt;
            r_awready <= 1'b0;
            // DECERR skips the downstream address phase
            r_wstate  <= (w_aw_tgt == T_ERR) ? W_DATA : W_ADDR;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_ADDR: begin
          if (w_m_awready) r_wstate <= W_DATA;
        end
        W_DATA: begin
          // wlast alone ends the data phase; beats are not counted
          if (s_wvalid && s_wready && s_wlast) r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (s_bvalid && s_bready) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign s_awready  = r_awready;
  assign m0_awvalid = (r_wstate == W_ADDR) && (r_wtgt == T_M0);
  assign m1_awvalid = (r_wstate == W_ADDR) && (r_wtgt == T_M1);
  assign m0_awaddr  = r_waddr;
  assign m0_awid    = r_wid;
  assign m0_awlen   = r_wlen;
  assign m0_awsize  = r_wsize;
  assign m0_awburst = r_wburst;
  assign m1_awaddr  = r_waddr;
  assign m1_awid    = r_wid;
  assign m1_awlen   = r_wlen;
  assign m1_awsize  = r_wsize;
  assign m1_awburst = r_wburst;

  always_comb begin
    s_wready  = 1'b0;
    m0_wvalid = 1'b0;
    m0_wdata  = '0;
    m0_wstrb  = '0;
    m0_wlast  = 1'b0;
    m1_wvalid = 1'b0;
    m1_wdata  = '0;
    m1_wstrb  = '0;
    m1_wlast  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = '0;
    s_bid     = '0;
    m0_bready = 1'b0;
    m1_bready = 1'b0;
    if (r_wstate == W_DATA) begin
      case (r_wtgt)
        T_M0: begin
          m0_wvalid = s_wvalid;
          m0_wdata  = s_wdata;
          m0_wstrb  = s_wstrb;
          m0_wlast  = s_wlast;
          s_wready  = m0_wready;
        end
        T_M1: begin
          m1_wvalid = s_wvalid;
          m1_wdata  = s_wdata;
          m1_wstrb  = s_wstrb;
          m1_wlast  = s_wlast;
          s_wready  = m1_wready;
        end
        default: s_wready = 1'b1;  // DECERR sinks the data
      endcase
    end else if (r_wstate == W_RESP) begin
      case (r_wtgt)
        T_M0: begin
          s_bvalid  = m0_bvalid;
          s_bresp   = m0_bresp;
          s_bid     = m0_bid;
          m0_bready = s_bready;
        end
        T_M1: begin
          s_bvalid  = m1_bvalid;
          s_bresp   = m1_bresp;
          s_bid     = m1_bid;
          m1_bready = s_bready;
        end
        default: begin
          s_bvalid = 1'b1;
          s_bresp  = 2'b11;
          s_bid    = r_wid;
        end
      endcase
    end
  end

  assign o_dbg_rstate = r_rstate;
  assign o_dbg_wstate = r_wstate;

endmodule

// File: doc/ysyx_23060229_xbar.md
# ysyx_23060229_xbar

AXI4 1-to-2 crossbar between the `ysyx_23060229` core's `io_master` port and the system slaves. Port m0 is main memory (`ysyx_23060229_memory`); port m1 is the MMIO slave (serial/CLINT). Unmapped addresses are answered by an internal DECERR responder. Read and write paths are independent; each path carries one transaction at a time, which matches the core's single-outstanding behaviour.

## Interface
Parameters:
- M0_BASE, 32'h8000_0000, base address of the m0 window.
- M0_MASK, 32'hF800_0000. An address hits m0 when (addr & M0_MASK) == M0_BASE.
- M1_BASE, 32'h1000_0000, base address of the m1 window.
- M1_MASK, 32'hF000_0000, mask for the m1 window. m0 has priority if both windows match.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- s_ar{valid,ready,addr,id,len,size,burst}  in/out(ready)  1,1,32,4,8,3,2  upstream AR channel, from the core.
- s_r{valid,ready,data,resp,last,id}  out/in(ready)  1,1,32,2,1,4  upstream R channel.
- s_aw{valid,ready,addr,id,len,size,burst}  in/out(ready)  1,1,32,4,8,3,2  upstream AW channel.
- s_w{valid,ready,data,strb,last}  in/out(ready)  1,1,32,4,1  upstream W channel.
- s_b{valid,ready,resp,id}  out/in(ready)  1,1,2,4  upstream B channel.
- m0_* and m1_*: the same five channels with the directions mirrored. These are the downstream master ports.

## Operation
Read FSM: R_IDLE, R_ADDR, R_DATA, R_ERR.
- R_IDLE: s_arready=1. On an s_ar handshake:
  - latch addr, id, len, size and burst;
  - decode the target (m0, m1 or ERR);
  - go to R_ADDR if the target is m0/m1, or to R_ERR if it is ERR.
- R_ADDR: drive the selected mX_arvalid and the latched fields from registers. Go to R_DATA on the mX_ar handshake.
- R_DATA: route the R channel combinationally.
  - s_r* = selected mX_r*; selected mX_rready = s_rready.
  - The unselected mX_rready is 0.
  - Go to R_IDLE on s_rvalid & s_rready & s_rlast.
- R_ERR: drive s_rvalid=1, rdata=0, rresp=2'b11 and rid=latched id.
  - Issue len+1 beats, counted by an 8-bit beat counter that resets to 0.
  - s_rlast is asserted on the beat where the count equals len.
  - Go to R_IDLE after the last handshake.

Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE: s_awready=1. On an s_aw handshake, latch the fields and decode the target, then go to W_ADDR (m0/m1) or W_DATA (ERR).
- W_ADDR: drive the selected mX_aw from registers. Go to W_DATA on the mX_aw handshake.
- W_DATA: route s_w to the selected mX_w combinationally; s_wready = mX_wready.
  - For ERR, s_wready=1 and the data is discarded.
  - Go to W_RESP on a handshake with s_wlast=1.
- W_RESP: route mX_b to s_b.
  - For ERR, drive s_bvalid=1, bresp=2'b11 and bid=latched id.
  - Go to W_IDLE on the s_b handshake.

Other rules:
- s_wready=0 outside W_DATA, so W beats that arrive before AW is accepted are held upstream.
- Read and write paths run concurrently, including to the same slave.
- Beat count is never checked against wlast; wlast alone terminates W_DATA.

## Timing
- Reset values: both FSMs in IDLE.
  - Every valid output and every ready output is 0, including s_arready and s_awready, which are registered.
  - All latched fields and the beat counter are 0.
  - All data, addr, id and resp outputs are 0.
- s_arready and s_awready rise on the first clock edge after reset is released.
- AR/AW latency: the mX_*valid is first asserted on the cycle after the upstream handshake. This is exactly one added cycle.
- R, W and B data paths add zero cycles in the m0/m1 cases.
- DECERR read: the first s_rvalid comes 1 cycle after the s_ar handshake.
- DECERR write: s_bvalid comes 1 cycle after the s_wlast handshake.
- All valids are held until their handshake completes; the payload is stable while valid=1 and ready=0.
- Reset asserted mid-transaction: both FSMs return to IDLE immediately and any in-flight transaction is dropped. Downstream slaves share the same reset.
- Back-to-back transactions: a new AR is accepted no earlier than 1 cycle after the previous rlast handshake. AW follows the same rule after the previous B handshake.

## Test plan
- Read to 0x8000_0000 (len=0): m0_arvalid is asserted 1 cycle after the s_ar handshake with araddr 0x8000_0000. m0 returns rdata 0x1234_5678 with rlast, which appears on s_r in the same cycle with rid echoed. m1 sees no activity.
- 4-beat burst write to 0x1000_0000 (len=3), with s_wvalid raised before s_awvalid:
  - s_wready stays 0 until the AW is forwarded on m1;
  - all 4 beats and their strb arrive at m1;
  - bresp 0 passes through to s_b.
- Read to 0x0000_1000 (len=1, id=5): two beats with rdata 0, rresp 2'b11 and rid 5; rlast only on the 2nd beat. Neither m0 nor m1 is touched.
- Write to an unmapped address 0x2000_0000 (len=0): the W beat is accepted, then s_bvalid=1 with bresp 2'b11 and bid echoed.
- Concurrent read from m0 and write to m1, with s_rready randomly deasserted: both transactions complete correctly and payloads stay stable while stalled.
- Reset pulsed low during R_DATA of a 4-beat burst: all outputs go to 0, and after release a fresh read to m0 completes normally.
